// File: rtl/sdram_burst_sched_if.sv
// Scheduler-to-SDRAM-controller request bundle: burst requests, start addresses, lengths, acks.
// Latency: none, signal grouping only.
// Backpressure: the controller throttles the scheduler through the per-direction data-phase acks.
// Ports (master = scheduler): drives sdram_{wr,rd}_req/_addr/_burst; receives sdram_{wr,rd}_ack.
interface sdram_burst_sched_if #(
    parameter int ADDR_W = 24
);
    logic              sdram_wr_req;
    logic              sdram_rd_req;
    logic [ADDR_W-1:0] sdram_wr_addr;
    logic [ADDR_W-1:0] sdram_rd_addr;
    logic [9:0]        sdram_wr_burst;
    logic [9:0]        sdram_rd_burst;
    logic              sdram_wr_ack;
    logic              sdram_rd_ack;

    modport master (
        output sdram_wr_req, sdram_rd_req, sdram_wr_addr, sdram_rd_addr,
               sdram_wr_burst, sdram_rd_burst,
        input  sdram_wr_ack, sdram_rd_ack
    );

    modport slave (
        input  sdram_wr_req, sdram_rd_req, sdram_wr_addr, sdram_rd_addr,
               sdram_wr_burst, sdram_rd_burst,
        output sdram_wr_ack, sdram_rd_ack
    );
endinterface

// File: rtl/sdram_burst_sched.sv
// Round-robin write/read burst scheduler with wrapping address pointers for an SDRAM controller.
// Latency: request rises 2 cycles after eligibility; the pointer advances 1 cycle after the ack falls.
// Backpressure: one burst in flight; a new request waits for the active burst's ack to fall.
// Ports: clk/rst_n; init_done, FIFO levels, address windows, burst lengths, load pulses and
//        read_valid in; sd (master) carries req/addr/burst out and acks in; *_fifo_clr out.
module sdram_burst_sched #(
    parameter int ADDR_W = 24,
    parameter int LVL_W  = 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sdram_init_done,
    input  logic [LVL_W-1:0]     wr_fifo_level,
    input  logic [LVL_W-1:0]     rd_fifo_level,
    input  logic [ADDR_W-1:0]    wr_min_addr,
    input  logic [ADDR_W-1:0]    wr_max_addr,
    input  logic [ADDR_W-1:0]    rd_min_addr,
    input  logic [ADDR_W-1:0]    rd_max_addr,
    input  logic [9:0]           wr_burst_len,
    input  logic [9:0]           rd_burst_len,
    input  logic                 wr_load,
    input  logic                 rd_load,
    input  logic                 read_valid,
    sdram_burst_sched_if.master  sd,
    output logic                 wr_fifo_clr,
    output logic                 rd_fifo_clr
);
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_BUSY, RD_REQ, RD_BUSY} state_t;

    localparam logic [LVL_W:0] FIFO_DEPTH = (LVL_W+1)'(1024);

    state_t            state_q, state_d;
    logic              wr_req_q, wr_req_d, rd_req_q, rd_req_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [9:0]        wr_burst_q, wr_burst_d, rd_burst_q, rd_burst_d;
    logic              wr_clr_q, wr_clr_d, rd_clr_q, rd_clr_d;
    logic              last_rd_q, last_rd_d;
    logic              wr_ack_dly_q, wr_ack_dly_d, rd_ack_dly_q, rd_ack_dly_d;
    // A load seen during a burst cancels that burst's end-of-burst pointer advance.
    logic              wr_skip_q, wr_skip_d, rd_skip_q, rd_skip_d;

    logic              wr_elig, rd_elig, wr_fall, rd_fall;

    // Next start address: step by the burst length, but wrap to the window base when the
    // following burst would no longer fit. Two extra bits keep the sums overflow-free.
    function automatic logic [ADDR_W-1:0] next_ptr(
        input logic [ADDR_W-1:0] addr,
        input logic [9:0]        len,
        input logic [ADDR_W-1:0] min_a,
        input logic [ADDR_W-1:0] max_a
    );
        logic [ADDR_W+1:0] len_x, cand, lim;
        len_x = (ADDR_W+2)'(len);
        cand  = (ADDR_W+2)'(addr) + len_x;
        lim   = (ADDR_W+2)'(max_a) + (ADDR_W+2)'(1);
        if (cand + len_x > lim) begin
            return min_a;
        end
        return cand[ADDR_W-1:0];
    endfunction

    always_comb begin
        wr_elig = sdram_init_done &
                  ({1'b0, wr_fifo_level} >= (LVL_W+1)'(wr_burst_len));
        rd_elig = sdram_init_done & read_valid &
                  ({1'b0, rd_fifo_level} < (FIFO_DEPTH - (LVL_W+1)'(rd_burst_len)));
        wr_fall = wr_ack_dly_q & ~sd.sdram_wr_ack;
        rd_fall = rd_ack_dly_q & ~sd.sdram_rd_ack;
    end

    always_comb begin
        state_d      = state_q;
        wr_req_d     = wr_req_q;
        rd_req_d     = rd_req_q;
        wr_addr_d    = wr_addr_q;
        rd_addr_d    = rd_addr_q;
        wr_burst_d   = wr_burst_q;
        rd_burst_d   = rd_burst_q;
        last_rd_d    = last_rd_q;
        wr_skip_d    = wr_skip_q;
        rd_skip_d    = rd_skip_q;
        wr_clr_d     = wr_load;
        rd_clr_d     = rd_load;
        wr_ack_dly_d = sd.sdram_wr_ack;
        rd_ack_dly_d = sd.sdram_rd_ack;

        case (state_q)
            IDLE: begin
                wr_skip_d = 1'b0;
                rd_skip_d = 1'b0;
                // last_rd_q set means read was served last, so write wins a tie.
                if (wr_elig && (!rd_elig || last_rd_q)) begin
                    state_d   = WR_REQ;
                    last_rd_d = 1'b0;
                end else if (rd_elig) begin
                    state_d   = RD_REQ;
                    last_rd_d = 1'b1;
                end
            end
            WR_REQ: begin
                if (!wr_req_q) begin
                    wr_req_d   = 1'b1;
                    wr_burst_d = wr_burst_len;
                end else if (sd.sdram_wr_ack) begin
                    wr_req_d = 1'b0;
                    state_d  = WR_BUSY;
                end
            end
            WR_BUSY: begin
                if (wr_fall) begin
                    state_d = IDLE;
                    if (!wr_skip_q) begin
                        wr_addr_d = next_ptr(wr_addr_q, wr_burst_q, wr_min_addr, wr_max_addr);
                    end
                end
            end
            RD_REQ: begin
                if (!rd_req_q) begin
                    rd_req_d   = 1'b1;
                    rd_burst_d = rd_burst_len;
                end else if (sd.sdram_rd_ack) begin
                    rd_req_d = 1'b0;
                    state_d  = RD_BUSY;
                end
            end
            RD_BUSY: begin
                if (rd_fall) begin
                    state_d = IDLE;
                    if (!rd_skip_q) begin
                        rd_addr_d = next_ptr(rd_addr_q, rd_burst_q, rd_min_addr, rd_max_addr);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Load rewinds the pointer and wins over any advance computed above.
        if (wr_load) begin
            wr_addr_d = wr_min_addr;
            if (state_q == WR_REQ || state_q == WR_BUSY) begin
                wr_skip_d = 1'b1;
            end
        end
        if (rd_load) begin
            rd_addr_d = rd_min_addr;
            if (state_q == RD_REQ || state_q == RD_BUSY) begin
                rd_skip_d = 1'b1;
            end
        end

        if (!sdram_init_done) begin
            state_d  = IDLE;
            wr_req_d = 1'b0;
            rd_req_d = 1'b0;
        end
    end

    // Pointers reload from the window minimum while reset is held, so the window
    // can be reprogrammed under reset and is picked up on release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wr_req_q     <= 1'b0;
            rd_req_q     <= 1'b0;
            wr_addr_q    <= wr_min_addr;
            rd_addr_q    <= rd_min_addr;
            wr_burst_q   <= 10'd0;
            rd_burst_q   <= 10'd0;
            wr_clr_q     <= 1'b0;
            rd_clr_q     <= 1'b0;
            last_rd_q    <= 1'b1;
            wr_ack_dly_q <= 1'b0;
            rd_ack_dly_q <= 1'b0;
            wr_skip_q    <= 1'b0;
            rd_skip_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_req_q     <= wr_req_d;
            rd_req_q     <= rd_req_d;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            wr_burst_q   <= wr_burst_d;
            rd_burst_q   <= rd_burst_d;
            wr_clr_q     <= wr_clr_d;
            rd_clr_q     <= rd_clr_d;
            last_rd_q    <= last_rd_d;
            wr_ack_dly_q <= wr_ack_dly_d;
            rd_ack_dly_q <= rd_ack_dly_d;
            wr_skip_q    <= wr_skip_d;
            rd_skip_q    <= rd_skip_d;
        end
    end

    assign sd.sdram_wr_req   = wr_req_q;
    assign sd.sdram_rd_req   = rd_req_q;
    assign sd.sdram_wr_addr  = wr_addr_q;
    assign sd.sdram_rd_addr  = rd_addr_q;
    assign sd.sdram_wr_burst = wr_burst_q;
    assign sd.sdram_rd_burst = rd_burst_q;
    assign wr_fifo_clr       = wr_clr_q;
    assign rd_fifo_clr       = rd_clr_q;
endmodule

// File: tb/tb_sdram_burst_sched.sv
module tb_sdram_burst_sched;
    localparam int AW = 24;
    localparam int LW = 11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sdram_init_done = 1'b0;
    logic [LW-1:0] wr_fifo_level = '0;
    logic [LW-1:0] rd_fifo_level = '0;
    logic [AW-1:0] wr_min_addr = '0, wr_max_addr = '0, rd_min_addr = '0, rd_max_addr = '0;
    logic [9:0]    wr_burst_len = 10'd256, rd_burst_len = 10'd256;
    logic          wr_load = 1'b0, rd_load = 1'b0, read_valid = 1'b0;
    logic          wr_fifo_clr, rd_fifo_clr;

    int checks = 0;
    int errors = 0;

    sdram_burst_sched_if #(.ADDR_W(AW)) sd ();

    sdram_burst_sched #(.ADDR_W(AW), .LVL_W(LW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sdram_init_done (sdram_init_done),
        .wr_fifo_level   (wr_fifo_level),
        .rd_fifo_level   (rd_fifo_level),
        .wr_min_addr     (wr_min_addr),
        .wr_max_addr     (wr_max_addr),
        .rd_min_addr     (rd_min_addr),
        .rd_max_addr     (rd_max_addr),
        .wr_burst_len    (wr_burst_len),
        .rd_burst_len    (rd_burst_len),
        .wr_load         (wr_load),
        .rd_load         (rd_load),
        .read_valid      (read_valid),
        .sd              (sd),
        .wr_fifo_clr     (wr_fifo_clr),
        .rd_fifo_clr     (rd_fifo_clr)
    );

    always #5 clk = ~clk;

    // Reference address rule: step by len, wrap to min once the next burst would overrun max.
    function automatic int unsigned model_next(int unsigned a, int unsigned len,
                                               int unsigned mn, int unsigned mx);
        if (a + len + len > mx + 1) return mn;
        return a + len;
    endfunction

    // Waits for either request; flags both high and timeout.
    task automatic wait_grant(output bit is_rd, output bit ok);
        ok = 1'b0;
        is_rd = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (sd.sdram_wr_req || sd.sdram_rd_req) begin
                ok = 1'b1;
                is_rd = sd.sdram_rd_req;
                checks++;
                if (sd.sdram_wr_req && sd.sdram_rd_req) begin
                    errors++;
                    $display("FAIL one_hot_req wr=%0b rd=%0b required at most one", sd.sdram_wr_req, sd.sdram_rd_req);
                end
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout no request within 100 cycles");
        end
    endtask

    // Called at the negedge where the request is seen; returns one cycle after ack falls.
    task automatic ack_burst(input bit is_rd, input int ack_len);
        if (is_rd) sd.sdram_rd_ack = 1'b1; else sd.sdram_wr_ack = 1'b1;
        @(negedge clk);
        checks++;
        if ((is_rd ? sd.sdram_rd_req : sd.sdram_wr_req) !== 1'b0) begin
            errors++;
            $display("FAIL req_drop_after_ack dir_rd=%0b req=%0b required 0", is_rd, is_rd ? sd.sdram_rd_req : sd.sdram_wr_req);
        end
        for (int i = 1; i < ack_len; i++) @(negedge clk);
        sd.sdram_wr_ack = 1'b0;
        sd.sdram_rd_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_load(input bit is_rd, input logic [AW-1:0] mn);
        if (is_rd) rd_load = 1'b1; else wr_load = 1'b1;
        @(negedge clk);
        rd_load = 1'b0;
        wr_load = 1'b0;
        checks++;
        if ((is_rd ? rd_fifo_clr : wr_fifo_clr) !== 1'b1) begin
            errors++;
            $display("FAIL clr_pulse dir_rd=%0b got=%0b required 1", is_rd, is_rd ? rd_fifo_clr : wr_fifo_clr);
        end
        @(negedge clk);
        checks++;
        if ((is_rd ? rd_fifo_clr : wr_fifo_clr) !== 1'b0) begin
            errors++;
            $display("FAIL clr_single dir_rd=%0b got=%0b required 0", is_rd, is_rd ? rd_fifo_clr : wr_fifo_clr);
        end
        checks++;
        if ((is_rd ? sd.sdram_rd_addr : sd.sdram_wr_addr) !== mn) begin
            errors++;
            $display("FAIL load_addr dir_rd=%0b got=%0d required %0d", is_rd, is_rd ? sd.sdram_rd_addr : sd.sdram_wr_addr, mn);
        end
    endtask

    task automatic test_reset();
        wr_min_addr = 24'd100;
        rd_min_addr = 24'd300;
        sd.sdram_wr_ack = 1'b0;
        sd.sdram_rd_ack = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (sd.sdram_wr_req !== 1'b0 || sd.sdram_rd_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_req wr=%0b rd=%0b required 0 0", sd.sdram_wr_req, sd.sdram_rd_req);
        end
        checks++;
        if (wr_fifo_clr !== 1'b0 || rd_fifo_clr !== 1'b0) begin
            errors++;
            $display("FAIL reset_clr wr=%0b rd=%0b required 0 0", wr_fifo_clr, rd_fifo_clr);
        end
        checks++;
        if (sd.sdram_wr_addr !== 24'd100 || sd.sdram_rd_addr !== 24'd300) begin
            errors++;
            $display("FAIL reset_addr wr=%0d rd=%0d required 100 300", sd.sdram_wr_addr, sd.sdram_rd_addr);
        end
        checks++;
        if (sd.sdram_wr_burst !== 10'd0 || sd.sdram_rd_burst !== 10'd0) begin
            errors++;
            $display("FAIL reset_burst wr=%0d rd=%0d required 0 0", sd.sdram_wr_burst, sd.sdram_rd_burst);
        end
        rst_n = 1'b1;
        sdram_init_done = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_latency();
        bit is_rd, ok;
        int n;
        wr_burst_len = 10'd256;
        wr_min_addr = 24'd0;
        wr_max_addr = 24'd1023;
        wr_fifo_level = 11'd255;
        read_valid = 1'b0;
        do_load(1'b0, 24'd0);
        repeat (3) @(negedge clk);
        checks++;
        if (sd.sdram_wr_req !== 1'b0) begin
            errors++;
            $display("FAIL level_255_no_req got=%0b required 0", sd.sdram_wr_req);
        end
        wr_fifo_level = 11'd256;
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (sd.sdram_wr_req) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL req_latency got=%0d required 2", n);
        end
        wr_fifo_level = 11'd0;
        if (n != 0) begin
            ack_burst(1'b0, 255);
            checks++;
            if (sd.sdram_wr_addr !== 24'd256 || sd.sdram_wr_burst !== 10'd256) begin
                errors++;
                $display("FAIL latency_advance addr=%0d burst=%0d required 256 256", sd.sdram_wr_addr, sd.sdram_wr_burst);
            end
        end
        is_rd = 1'b0;
        ok = 1'b0;
    endtask

    task automatic test_window_wrap();
        int unsigned mn [3], mx [3], ln [3];
        int unsigned expa;
        bit is_rd, ok;
        mn[0] = 0; mx[0] = 1023; ln[0] = 256;
        mn[1] = 0; mx[1] = 999;  ln[1] = 256;
        ln[2] = $urandom_range(1, 512);
        mn[2] = $urandom_range(0, 5000);
        mx[2] = mn[2] + ln[2] * $urandom_range(1, 5) + $urandom_range(0, ln[2]) - 1;
        read_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            wr_fifo_level = 11'd0;
            wr_min_addr = AW'(mn[c]);
            wr_max_addr = AW'(mx[c]);
            wr_burst_len = 10'(ln[c]);
            repeat (2) @(negedge clk);
            do_load(1'b0, AW'(mn[c]));
            expa = mn[c];
            wr_fifo_level = 11'd1024;
            for (int b = 0; b < 6; b++) begin
                wait_grant(is_rd, ok);
                if (!ok) break;
                wr_fifo_level = 11'd0;
                checks++;
                if (is_rd || sd.sdram_wr_addr !== AW'(expa) || sd.sdram_wr_burst !== 10'(ln[c])) begin
                    errors++;
                    $display("FAIL wrap_grant cfg=%0d burst=%0d rd=%0b addr=%0d len=%0d required rd=0 addr=%0d len=%0d",
                             c, b, is_rd, sd.sdram_wr_addr, sd.sdram_wr_burst, expa, ln[c]);
                end
                ack_burst(1'b0, $urandom_range(1, 6));
                expa = model_next(expa, ln[c], mn[c], mx[c]);
                checks++;
                if (sd.sdram_wr_addr !== AW'(expa)) begin
                    errors++;
                    $display("FAIL wrap_advance cfg=%0d burst=%0d got=%0d required %0d", c, b, sd.sdram_wr_addr, expa);
                end
                wr_fifo_level = 11'd1024;
            end
            wr_fifo_level = 11'd0;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_round_robin();
        int unsigned wa, ra, wl, rl;
        bit exp_rd, is_rd, ok;
        wr_fifo_level = 11'd0;
        read_valid = 1'b0;
        wl = $urandom_range(1, 512);
        rl = $urandom_range(1, 512);
        wr_burst_len = 10'(wl);
        rd_burst_len = 10'(rl);
        wr_min_addr = 24'd0;    wr_max_addr = 24'd4095;
        rd_min_addr = 24'd8192; rd_max_addr = 24'd12287;
        rd_fifo_level = 11'd0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wa = 0;
        ra = 8192;
        exp_rd = 1'b0;
        wr_fifo_level = 11'd1024;
        read_valid = 1'b1;
        for (int g = 0; g < 8; g++) begin
            wait_grant(is_rd, ok);
            if (!ok) break;
            wr_fifo_level = 11'd0;
            read_valid = 1'b0;
            checks++;
            if (is_rd !== exp_rd) begin
                errors++;
                $display("FAIL rr_order grant=%0d got_rd=%0b required_rd=%0b", g, is_rd, exp_rd);
            end
            checks++;
            if ((is_rd ? sd.sdram_rd_addr : sd.sdram_wr_addr) !== AW'(is_rd ? ra : wa)) begin
                errors++;
                $display("FAIL rr_addr grant=%0d got=%0d required %0d", g, is_rd ? sd.sdram_rd_addr : sd.sdram_wr_addr, is_rd ? ra : wa);
            end
            ack_burst(is_rd, $urandom_range(1, 5));
            if (is_rd) ra = model_next(ra, rl, 8192, 12287);
            else       wa = model_next(wa, wl, 0, 4095);
            exp_rd = !is_rd;
            wr_fifo_level = 11'd1024;
            read_valid = 1'b1;
        end
        wr_fifo_level = 11'd0;
        read_valid = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_load_during_busy();
        bit is_rd, ok;
        int clr_cnt;
        rd_min_addr = 24'd0;
        rd_max_addr = 24'd1023;
        rd_burst_len = 10'd256;
        rd_fifo_level = 11'd0;
        do_load(1'b1, 24'd0);
        for (int g = 0; g < 2; g++) begin
            read_valid = 1'b1;
            wait_grant(is_rd, ok);
            read_valid = 1'b0;
            if (ok) ack_burst(1'b1, 3);
        end
        read_valid = 1'b1;
        wait_grant(is_rd, ok);
        read_valid = 1'b0;
        checks++;
        if (!is_rd || sd.sdram_rd_addr !== 24'd512) begin
            errors++;
            $display("FAIL busy_load_start rd=%0b addr=%0d required 1 512", is_rd, sd.sdram_rd_addr);
        end
        sd.sdram_rd_ack = 1'b1;
        @(negedge clk);
        rd_load = 1'b1;
        @(negedge clk);
        rd_load = 1'b0;
        clr_cnt = int'(rd_fifo_clr);
        repeat (4) begin
            @(negedge clk);
            clr_cnt += int'(rd_fifo_clr);
        end
        sd.sdram_rd_ack = 1'b0;
        repeat (3) begin
            @(negedge clk);
            clr_cnt += int'(rd_fifo_clr);
        end
        checks++;
        if (sd.sdram_rd_addr !== 24'd0) begin
            errors++;
            $display("FAIL busy_load_addr got=%0d required 0", sd.sdram_rd_addr);
        end
        checks++;
        if (clr_cnt != 1) begin
            errors++;
            $display("FAIL busy_load_clr_count got=%0d required 1", clr_cnt);
        end
    endtask

    task automatic test_reset_mid_burst();
        bit is_rd, ok;
        wr_min_addr = 24'd0;
        wr_max_addr = 24'd1023;
        wr_burst_len = 10'd100;
        wr_fifo_level = 11'd1024;
        read_valid = 1'b0;
        wait_grant(is_rd, ok);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (sd.sdram_wr_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_drops_req got=%0b required 0", sd.sdram_wr_req);
        end
        wr_min_addr = 24'd77;
        @(negedge clk);
        checks++;
        if (sd.sdram_wr_addr !== 24'd77) begin
            errors++;
            $display("FAIL reset_tracks_min got=%0d required 77", sd.sdram_wr_addr);
        end
        read_valid = 1'b1;
        rd_fifo_level = 11'd0;
        rst_n = 1'b1;
        wait_grant(is_rd, ok);
        wr_fifo_level = 11'd0;
        read_valid = 1'b0;
        checks++;
        if (!ok || is_rd !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_grant got_rd=%0b required_rd=0", is_rd);
        end
        if (ok) ack_burst(1'b0, 2);
    endtask

    task automatic test_init_drop();
        bit is_rd, ok;
        wr_fifo_level = 11'd1024;
        wait_grant(is_rd, ok);
        wr_fifo_level = 11'd0;
        sdram_init_done = 1'b0;
        @(negedge clk);
        checks++;
        if (sd.sdram_wr_req !== 1'b0) begin
            errors++;
            $display("FAIL init_drop_req got=%0b required 0", sd.sdram_wr_req);
        end
        sdram_init_done = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (sd.sdram_wr_req !== 1'b0 || sd.sdram_rd_req !== 1'b0) begin
            errors++;
            $display("FAIL init_drop_idle wr=%0b rd=%0b required 0 0", sd.sdram_wr_req, sd.sdram_rd_req);
        end
    endtask

    initial begin
        sd.sdram_wr_ack = 1'b0;
        sd.sdram_rd_ack = 1'b0;
        test_reset();
        test_latency();
        test_window_wrap();
        test_round_robin();
        test_load_during_busy();
        test_reset_mid_burst();
        test_init_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
